// File: rtl/topk_pkg.sv
// Shared types and helpers for the streaming top-K selector.
package topk_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Widest sample value the compare helper handles; callers zero-extend into it.
  localparam int CMP_W = 64;

  function automatic int entry_width(input int id_w, input int data_w);
    return id_w + data_w;
  endfunction

  // Strict ordering so equal values never displace an earlier arrival.
  function automatic logic better(input logic [CMP_W-1:0] a,
                                  input logic [CMP_W-1:0] b,
                                  input logic             select_max);
    return select_max ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/topk_cell.sv
// One rank slot of the top-K queue: either takes the candidate, takes the
// upper neighbour's contents (shift down), or holds.
module topk_cell #(
  parameter int TDATA_WIDTH = 8,
  parameter int ID_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   insert,
  input  logic                   select_max,
  input  logic [TDATA_WIDTH-1:0] cand_value,
  input  logic [ID_WIDTH-1:0]    cand_id,
  input  logic [TDATA_WIDTH-1:0] upper_value,
  input  logic [ID_WIDTH-1:0]    upper_id,
  input  logic                   upper_valid,
  input  logic                   upper_accept,
  output logic [TDATA_WIDTH-1:0] value,
  output logic [ID_WIDTH-1:0]    id,
  output logic                   valid,
  output logic                   accept
);
  import topk_pkg::*;

  assign accept = !valid || better(CMP_W'(cand_value), CMP_W'(value), select_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (insert) begin
      if (upper_accept)
        valid <= upper_valid;
      else if (accept)
        valid <= 1'b1;
    end
  end

  // Payload carries no reset; it is only observed when valid is set.
  always_ff @(posedge clk) begin
    if (insert && !clear) begin
      if (upper_accept) begin
        value <= upper_value;
        id    <= upper_id;
      end else if (accept) begin
        value <= cand_value;
        id    <= cand_id;
      end
    end
  end

endmodule

// File: rtl/topk_selector.sv
// Streaming top-K selector: ranks each tlast-delimited frame, then drains it.
// Optional macro TOPK_SELECTOR_TUSER_EN adds m_axis_tuser (beats per frame).
module topk_selector #(
  parameter int QUEUE_SIZE  = 8,
  parameter int TDATA_WIDTH = 8,
  parameter int ID_WIDTH    = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            select_max,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [ID_WIDTH+TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tlast
`ifdef TOPK_SELECTOR_TUSER_EN
  ,
  output logic [ID_WIDTH-1:0]             m_axis_tuser
`endif
);
  import topk_pkg::*;

  localparam int ENTRY_W = entry_width(ID_WIDTH, TDATA_WIDTH);
  localparam int PTR_W   = $clog2(QUEUE_SIZE);

  state_t                  state;
  logic [ID_WIDTH-1:0]     id_cnt;
  logic                    in_frame;
  logic                    mode_q;
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        ptr_nxt;

  logic [TDATA_WIDTH-1:0]  val    [QUEUE_SIZE];
  logic [ID_WIDTH-1:0]     ids    [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]   valid;
  logic [QUEUE_SIZE-1:0]   accept;
  logic [QUEUE_SIZE:0]     valid_ext;

  logic [TDATA_WIDTH-1:0]  up_val [QUEUE_SIZE];
  logic [ID_WIDTH-1:0]     up_id  [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]   up_valid;
  logic [QUEUE_SIZE-1:0]   up_accept;

  logic                    beat;
  logic                    mode_eff;
  logic                    drain_hs;
  logic                    drain_done;
  logic [ENTRY_W-1:0]      first_entry;
  logic                    first_last;
  logic [ENTRY_W-1:0]      sel_entry;
  logic                    sel_last;
  logic                    unused_accept;

  assign beat       = s_axis_tvalid & s_axis_tready;
  // The first beat of a frame uses the live mode input; later beats the latched one.
  assign mode_eff   = in_frame ? mode_q : select_max;
  assign drain_hs   = m_axis_tvalid & m_axis_tready;
  assign drain_done = drain_hs & m_axis_tlast;
  assign ptr_nxt    = ptr + 1'b1;
  assign valid_ext  = {1'b0, valid};
  assign unused_accept = accept[QUEUE_SIZE-1];

  always_comb begin
    up_val[0]    = '0;
    up_id[0]     = '0;
    up_valid[0]  = 1'b0;
    up_accept[0] = 1'b0;
    for (int i = 1; i < QUEUE_SIZE; i++) begin
      up_val[i]    = val[i-1];
      up_id[i]     = ids[i-1];
      up_valid[i]  = valid[i-1];
      up_accept[i] = accept[i-1];
    end
  end

  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_rank
    topk_cell #(
      .TDATA_WIDTH(TDATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH)
    ) u_cell (
      .clk         (aclk),
      .rst_n       (aresetn),
      .clear       (drain_done),
      .insert      (beat),
      .select_max  (mode_eff),
      .cand_value  (s_axis_tdata),
      .cand_id     (id_cnt),
      .upper_value (up_val[i]),
      .upper_id    (up_id[i]),
      .upper_valid (up_valid[i]),
      .upper_accept(up_accept[i]),
      .value       (val[i]),
      .id          (ids[i]),
      .valid       (valid[i]),
      .accept      (accept[i])
    );
  end

  // Rank 0 and rank 1 validity as they will be after the tlast beat lands,
  // so the first result is ready in the very first drain cycle.
  assign first_entry = accept[0] ? {id_cnt, s_axis_tdata} : {ids[0], val[0]};
  assign first_last  = !(accept[0] ? valid[0] : (accept[1] | valid[1]));

  always_comb begin
    sel_entry = '0;
    sel_last  = 1'b1;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      if (ptr_nxt == PTR_W'(i)) begin
        sel_entry = {ids[i], val[i]};
        sel_last  = !valid_ext[i+1];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ACCUM;
      s_axis_tready <= 1'b0;
      id_cnt        <= '0;
      in_frame      <= 1'b0;
      mode_q        <= 1'b0;
      ptr           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
`ifdef TOPK_SELECTOR_TUSER_EN
      m_axis_tuser  <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          s_axis_tready <= 1'b1;
          if (beat) begin
            id_cnt   <= id_cnt + 1'b1;
            in_frame <= 1'b1;
            if (!in_frame)
              mode_q <= select_max;
            if (s_axis_tlast) begin
              state         <= DRAIN;
              s_axis_tready <= 1'b0;
              ptr           <= '0;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= first_entry;
              m_axis_tlast  <= first_last;
`ifdef TOPK_SELECTOR_TUSER_EN
              m_axis_tuser  <= id_cnt + 1'b1;
`endif
            end
          end
        end
        DRAIN: begin
          if (drain_hs) begin
            if (m_axis_tlast) begin
              state         <= ACCUM;
              s_axis_tready <= 1'b1;
              id_cnt        <= '0;
              in_frame      <= 1'b0;
              ptr           <= '0;
              m_axis_tvalid <= 1'b0;
              m_axis_tdata  <= '0;
              m_axis_tlast  <= 1'b0;
            end else begin
              ptr          <= ptr_nxt;
              m_axis_tdata <= sel_entry;
              m_axis_tlast <= sel_last;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_topk_selector.sv
// Bench for topk_selector (K=4): directed table, reset corners, random frames vs. a sort model.
module tb_topk_selector;
  localparam int K  = 4;
  localparam int DW = 8;
  localparam int IW = 32;
  localparam int EW = IW + DW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          select_max = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [EW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
`ifdef TOPK_SELECTOR_TUSER_EN
  logic [IW-1:0] m_axis_tuser;
`endif

  int checks = 0;
  int errors = 0;

  int            fr_vals[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  bit            got_last[$];

  typedef struct {
    int              len;
    bit              mode;
    bit              toggle;
    logic [0:9][7:0] vals;
    int              exp_n;
    logic [0:3][7:0] exp_val;
    logic [0:3][7:0] exp_id;
    int              hold;
  } vec_t;

  vec_t vecs[7];

  always #5 aclk = ~aclk;

  topk_selector #(
    .QUEUE_SIZE (K),
    .TDATA_WIDTH(DW),
    .ID_WIDTH   (IW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .select_max   (select_max),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast)
`ifdef TOPK_SELECTOR_TUSER_EN
    ,
    .m_axis_tuser (m_axis_tuser)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: stable selection of the K best values, earlier arrival wins ties.
  task automatic model(input bit mode);
    bit used[$];
    int n;
    n = fr_vals.size();
    exp_q.delete();
    for (int j = 0; j < n; j++) used.push_back(1'b0);
    for (int r = 0; r < n && r < K; r++) begin
      int best;
      best = -1;
      for (int j = 0; j < n; j++)
        if (!used[j] && (best < 0 ||
            (mode ? (fr_vals[j] > fr_vals[best]) : (fr_vals[j] < fr_vals[best]))))
          best = j;
      used[best] = 1'b1;
      exp_q.push_back({IW'(best), DW'(fr_vals[best])});
    end
  endtask

  task automatic send_frame(input bit mode, input bit toggle, input bit gaps);
    int n;
    for (int b = 0; b < fr_vals.size(); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
      end
      @(negedge aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(fr_vals[b]);
      s_axis_tlast  = (b == fr_vals.size() - 1);
      select_max    = (b == 0) ? mode : (toggle ? ~select_max : select_max);
      n = 0;
      while (!s_axis_tready && n < 50) begin
        @(negedge aclk);
        n++;
      end
      check("tready_wait", 64'(n < 50), 64'(1));
      @(posedge aclk);
    end
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic recv_frame(input int hold, input bit rnd);
    int            cyc;
    bit            done;
    bit            stall;
    logic [EW-1:0] prev;
    cyc = 0; done = 1'b0; stall = 1'b0; prev = '0;
    got_q.delete();
    got_last.delete();
    while (!done && cyc < 300) begin
      @(negedge aclk);
      if (cyc == 0) check("drain_latency", 64'(m_axis_tvalid), 64'(1));
      if (m_axis_tvalid) begin
        if (stall) check("stall_stable", 64'(m_axis_tdata), 64'(prev));
        check("in_ready_low", 64'(s_axis_tready), 64'(0));
`ifdef TOPK_SELECTOR_TUSER_EN
        check("tuser", 64'(m_axis_tuser), 64'(fr_vals.size()));
`endif
        m_axis_tready = (cyc < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        if (m_axis_tready) begin
          got_q.push_back(m_axis_tdata);
          got_last.push_back(m_axis_tlast);
          done = m_axis_tlast;
        end
        prev  = m_axis_tdata;
        stall = !m_axis_tready;
      end else begin
        m_axis_tready = 1'b0;
      end
      cyc++;
    end
    check("drain_done", 64'(done), 64'(1));
    @(negedge aclk);
    m_axis_tready = 1'b0;
    if (done) begin
      check("post_tvalid", 64'(m_axis_tvalid), 64'(0));
      check("post_tready", 64'(s_axis_tready), 64'(1));
    end
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_id"},    64'(got_q[i][EW-1:DW]), 64'(exp_q[i][EW-1:DW]));
      check({tag, "_value"}, 64'(got_q[i][DW-1:0]),  64'(exp_q[i][DW-1:0]));
      check({tag, "_tlast"}, 64'(got_last[i]),       64'(i == exp_q.size() - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5, 1'b0, 1'b1, {8'd9, 8'd3, 8'd7, 8'd3, 8'd1, 40'd0}, 4,
                {8'd1, 8'd3, 8'd3, 8'd7}, {8'd4, 8'd1, 8'd3, 8'd2}, 0};
    vecs[1] = '{5, 1'b1, 1'b1, {8'd9, 8'd3, 8'd7, 8'd3, 8'd1, 40'd0}, 4,
                {8'd9, 8'd7, 8'd3, 8'd3}, {8'd0, 8'd2, 8'd1, 8'd3}, 0};
    vecs[2] = '{2, 1'b0, 1'b0, {8'd5, 8'd2, 64'd0}, 2,
                {8'd2, 8'd5, 16'd0}, {8'd1, 8'd0, 16'd0}, 0};
    vecs[3] = '{6, 1'b0, 1'b0, {8'd8, 8'd6, 8'd4, 8'd2, 8'd0, 8'd1, 32'd0}, 4,
                {8'd0, 8'd1, 8'd2, 8'd4}, {8'd4, 8'd5, 8'd3, 8'd2}, 5};
    vecs[4] = '{3, 1'b1, 1'b0, {8'd1, 8'd2, 8'd3, 56'd0}, 3,
                {8'd3, 8'd2, 8'd1, 8'd0}, {8'd2, 8'd1, 8'd0, 8'd0}, 5};
    vecs[5] = '{10, 1'b0, 1'b0, {8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5, 8'd3}, 4,
                {8'd1, 8'd1, 8'd2, 8'd3}, {8'd1, 8'd3, 8'd6, 8'd0}, 0};
    vecs[6] = '{5, 1'b1, 1'b0, {8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 40'd0}, 4,
                {8'd6, 8'd6, 8'd6, 8'd6}, {8'd0, 8'd1, 8'd2, 8'd3}, 0};

    repeat (3) @(negedge aclk);
    check("rst_tready", 64'(s_axis_tready), 64'(0));
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata",  64'(m_axis_tdata),  64'(0));
    check("rst_tlast",  64'(m_axis_tlast),  64'(0));
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_tready", 64'(s_axis_tready), 64'(1));

    for (int v = 0; v < 7; v++) begin
      fr_vals.delete();
      exp_q.delete();
      for (int b = 0; b < vecs[v].len; b++) fr_vals.push_back(int'(vecs[v].vals[b]));
      for (int r = 0; r < vecs[v].exp_n; r++)
        exp_q.push_back({IW'(vecs[v].exp_id[r]), vecs[v].exp_val[r]});
      send_frame(vecs[v].mode, vecs[v].toggle, 1'b0);
      recv_frame(vecs[v].hold, 1'b0);
      compare($sformatf("vec%0d", v));
    end

    // Reset while draining: outputs drop at once, the next frame starts clean.
    fr_vals = '{9, 3, 7};
    send_frame(1'b0, 1'b0, 1'b0);
    @(negedge aclk);
    check("mid_tvalid", 64'(m_axis_tvalid), 64'(1));
    m_axis_tready = 1'b1;
    @(negedge aclk);
    m_axis_tready = 1'b0;
    #1;
    aresetn = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("arst_tdata",  64'(m_axis_tdata),  64'(0));
    check("arst_tlast",  64'(m_axis_tlast),  64'(0));
    check("arst_tready", 64'(s_axis_tready), 64'(0));
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("arst_rel_tready", 64'(s_axis_tready), 64'(1));
    check("arst_rel_tvalid", 64'(m_axis_tvalid), 64'(0));
    fr_vals = '{4};
    exp_q.delete();
    exp_q.push_back({IW'(0), DW'(4)});
    send_frame(1'b0, 1'b0, 1'b0);
    recv_frame(0, 1'b0);
    compare("after_reset");

    for (int f = 0; f < 40; f++) begin
      bit mode;
      int len;
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 12);
      fr_vals.delete();
      for (int b = 0; b < len; b++) fr_vals.push_back($urandom_range(0, 15));
      model(mode);
      send_frame(mode, 1'($urandom_range(0, 1)), 1'b1);
      recv_frame($urandom_range(0, 3), 1'b1);
      compare($sformatf("rand%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
